// File: rtl/div_seq.sv
// div_seq: multi-cycle 32-bit restoring divider (DIV / DIVU) for the EX stage.
// Holds the pipeline through stallreq_o while a divide is in flight and then
// presents {remainder, quotient} with ready_o until EX drops start_i.
// Optional feature macro: DIV_ZERO_DETECT_EN. When it is defined, a zero
// divisor takes a short BYZERO path that returns {0,0}. When it is undefined,
// a zero divisor runs the normal 32 iterations.
//
// Handshake: start_i is a level request that EX holds until it sees ready_o.
// A request is accepted only in FREE with annul_i low. The result stays valid
// (ready_o=1) for as long as start_i stays high. start_i must be low for at
// least one cycle before the next request.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] p_q, p_d;
  logic [31:0] q_q, q_d;
  logic [31:0] div_q, div_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] mag_a, mag_b;
  logic [32:0] p_sh;
  logic [31:0] q_sh;
  logic [33:0] trial;
  logic [32:0] p_it;
  logic [31:0] q_it;
  logic [31:0] quo_fix, rem_fix;

  // Operand magnitudes and one shift-subtract step of the restoring divider.
  always_comb begin
    mag_a = (signed_div_i & opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    mag_b = (signed_div_i & opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    p_sh  = {p_q[31:0], q_q[31]};
    q_sh  = {q_q[30:0], 1'b0};
    trial = {1'b0, p_sh} - {2'b00, div_q};
    if (!trial[33]) begin
      p_it = trial[32:0];
      q_it = {q_sh[31:1], 1'b1};
    end else begin
      p_it = p_sh;
      q_it = q_sh;
    end
    quo_fix = neg_quo_q ? (~q_it + 32'd1) : q_it;
    rem_fix = neg_rem_q ? (~p_it[31:0] + 32'd1) : p_it[31:0];
  end

  // Next-state, datapath updates and the stall request.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    q_d        = q_q;
    div_d      = div_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    stallreq_o = 1'b0;
    case (state_q)
      ST_FREE: begin
        ready_d  = 1'b0;
        result_d = 64'd0;
        if (start_i && !annul_i) begin
          stallreq_o = 1'b1;
          neg_quo_d  = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
          neg_rem_d  = signed_div_i & opdata1_i[31];
          div_d      = mag_b;
          p_d        = 33'd0;
          q_d        = mag_a;
          cnt_d      = 5'd0;
`ifdef DIV_ZERO_DETECT_EN
          state_d    = (opdata2_i == 32'd0) ? ST_BYZERO : ST_ON;
`else
          state_d    = ST_ON;
`endif
        end
      end
      ST_BYZERO: begin
        stallreq_o = 1'b1;
        result_d   = 64'd0;
        if (annul_i) begin
          state_d = ST_FREE;
          ready_d = 1'b0;
        end else begin
          state_d = ST_END;
          ready_d = 1'b1;
        end
      end
      ST_ON: begin
        stallreq_o = 1'b1;
        if (annul_i) begin
          state_d  = ST_FREE;
          cnt_d    = 5'd0;
          ready_d  = 1'b0;
          result_d = 64'd0;
        end else begin
          p_d = p_it;
          q_d = q_it;
          if (cnt_q == 5'd31) begin
            state_d  = ST_END;
            cnt_d    = 5'd0;
            result_d = {rem_fix, quo_fix};
            ready_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      ST_END: begin
        if (!start_i) begin
          state_d  = ST_FREE;
          ready_d  = 1'b0;
          result_d = 64'd0;
        end
      end
      default: begin
        state_d = ST_FREE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FREE;
      cnt_q     <= 5'd0;
      p_q       <= 33'd0;
      q_q       <= 32'd0;
      div_q     <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 64'd0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      q_q       <= q_d;
      div_q     <= div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed and randomized divides for div_seq against an
// arithmetic reference model (plain / and % on operand magnitudes).
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int n_cmp;
  int n_err;

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: quotient and remainder from magnitudes, then sign fix-up.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    ma = (sgn && a[31]) ? 32'd0 - a : a;
    mb = (sgn && b[31]) ? 32'd0 - b : b;
`ifdef DIV_ZERO_DETECT_EN
    if (mb == 32'd0) return 64'd0;
`endif
    if (mb == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (sgn && (a[31] != b[31])) q = 32'd0 - q;
    if (sgn && a[31]) r = 32'd0 - r;
    return {r, q};
  endfunction

  function automatic int ref_lat(input logic [31:0] b);
`ifdef DIV_ZERO_DETECT_EN
    if (b == 32'd0) return 1;
`endif
    return 32;
  endfunction

  // Full divide: present, wait for ready, check latency/stall/result, release.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic check_timing);
    logic [63:0] exp;
    int cyc, st;
    exp = ref_div(sgn, a, b);
    start_i      = 1'b1;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    #1;
    st  = stallreq_o ? 1 : 0;
    cyc = 0;
    while (cyc < 40) begin
      step();
      cyc++;
      if (ready_o) break;
      if (stallreq_o) st++;
    end
    chk({tag, "_ready"}, 64'(ready_o), 64'd1);
    chk({tag, "_result"}, result_o, exp);
    if (check_timing) begin
      chk({tag, "_latency"}, 64'(cyc - 1), 64'(ref_lat(b)));
      chk({tag, "_stall_cycles"}, 64'(st), 64'(ref_lat(b) + 1));
      chk({tag, "_stall_at_ready"}, 64'(stallreq_o), 64'd0);
    end
    step();
    chk({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
    chk({tag, "_hold_result"}, result_o, exp);
    start_i = 1'b0;
    step();
    chk({tag, "_free_ready"}, 64'(ready_o), 64'd0);
    chk({tag, "_free_result"}, result_o, 64'd0);
  endtask

  logic [31:0] ra, rb;
  logic        rs;
  int          seen;

  // Directed steps followed by random divides.
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    start_i = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = 32'd0;
    opdata2_i = 32'd0;
    annul_i = 1'b0;
    step();
    step();
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    chk("reset_stall", 64'(stallreq_o), 64'd0);
    rst = 1'b0;
    step();

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b1);
    chk("divu_100_7_const", ref_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_div("div_by_min", 1'b1, 32'd12345, 32'h8000_0000, 1'b0);
    run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 1'b0);
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 1'b1);
    run_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);

    // Annul at iteration 10: back to FREE, no result ever presented.
    start_i = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    step();
    repeat (10) step();
    annul_i = 1'b1;
    step();
    chk("annul_stall", 64'(stallreq_o), 64'd0);
    chk("annul_ready", 64'(ready_o), 64'd0);
    chk("annul_result", result_o, 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
    seen = 0;
    repeat (40) begin
      step();
      if (ready_o) seen++;
    end
    chk("annul_no_ready", 64'(seen), 64'd0);
    run_div("after_annul_20_4", 1'b0, 32'd20, 32'd4, 1'b1);

    // Reset at iteration 20.
    start_i = 1'b1;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    step();
    repeat (20) step();
    rst = 1'b1;
    step();
    chk("rst_mid_ready", 64'(ready_o), 64'd0);
    chk("rst_mid_result", result_o, 64'd0);
    rst = 1'b0;
    start_i = 1'b0;
    #1;
    chk("rst_mid_stall_idle", 64'(stallreq_o), 64'd0);
    step();
    chk("rst_mid_stall_idle2", 64'(stallreq_o), 64'd0);
    run_div("after_rst_1000_3", 1'b0, 32'd1000, 32'd3, 1'b1);

    // Random divides, with biased corner operands.
    for (int i = 0; i < 24; i++) begin
      rs = 1'(($urandom_range(0, 1)));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'($urandom_range(0, 15));
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = rb >> $urandom_range(1, 31);
        default: ;
      endcase
      run_div($sformatf("rand%0d", i), rs, ra, rb, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle 32-bit integer divide sequencer for the MIPS pipeline. Executes DIV and DIVU as a 32-iteration restoring shift-subtract. Drives the pipeline stall request, so EX, and the EX/MEM register behind it, hold while a divide is in flight. Returns {remainder, quotient}, which EX forwards as the hi/lo write for MEM.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  request from EX; held high until ready_o is seen.
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU; sampled with start_i.
- opdata1_i  in  32  dividend; sampled when the start is accepted.
- opdata2_i  in  32  divisor; sampled when the start is accepted.
- annul_i  in  1  cancel the in-flight divide (flush/exception).
- result_o  out  64  {remainder[63:32], quotient[31:0]}; valid while ready_o=1.
- ready_o  out  1  result valid.
- stallreq_o  out  1  combinational pipeline stall request.

## Operation
- States: FREE, BYZERO, ON, END. Reset: state=FREE, result_o=0, ready_o=0, iteration count=0.
- FREE:
  - start_i=1 and annul_i=0: latch operands, the signed flag and the sign bits.
  - If signed_div_i=1, replace each negative operand with its two's-complement magnitude.
  - Load partial remainder P=0 (33 bits) and quotient Q=|dividend|, then go to ON (or BYZERO, see Configuration).
- ON, one iteration per cycle, 32 iterations:
  - Shift {P,Q} left 1.
  - T = P − {1'b0,|divisor|}.
  - If T ≥ 0: P=T and Q[0]=1; else Q[0]=0.
  - Count 0..31.
- On iteration 32:
  - Quotient is negated if signed and the operand signs differ.
  - Remainder is negated if signed and the dividend is negative.
  - Register result_o and set ready_o=1; state=END.
- END: hold result_o and ready_o=1 while start_i=1. When start_i=0, go to FREE next edge with ready_o=0 and result_o=0.
- A new start is accepted only in FREE; start_i must drop for at least one cycle between operations.
- stallreq_o = (state∈{ON,BYZERO}) | (state=FREE & start_i & ~annul_i). It is 0 in END.
- annul_i=1 in ON or BYZERO: next edge state=FREE, ready_o stays 0, result_o=0, no result is ever presented. annul_i in FREE blocks acceptance. annul_i in END is ignored.
- rst overrides everything, including mid-operation: next edge returns all outputs and state to reset values.
- Arithmetic:
  - Magnitudes are 32-bit unsigned.
  - −2^31 / −1 yields quotient 0x80000000, remainder 0 (wrap, no trap).
  - −2^31 as a divisor is handled by the 33-bit P.

## Timing
- Accepting edge E0 (FREE→ON). Iterations occur on edges E1..E32. ready_o and result_o are visible after E32, i.e. 32 cycles after acceptance.
- stallreq_o is high from the cycle start_i is presented in FREE through the last ON cycle. It is low in the cycle ready_o is high, so EX advances with the result.
- BYZERO path: E0 FREE→BYZERO, E1 →END with ready_o=1.
- No pipelining: one divide at a time.

## Configuration
- DIV_ZERO_DETECT_EN defined:
  - divisor==0 at acceptance goes to BYZERO.
  - Result {0,0} is presented after 1 cycle (2 edges total).
- DIV_ZERO_DETECT_EN undefined:
  - divisor==0 runs the normal 32 iterations.
  - Raw quotient = 0xFFFFFFFF, raw remainder = |dividend|, then the normal sign correction applies.
  - Latency is 32 cycles.

## Test plan
- DIVU 100/7 → after 32 cycles ready_o=1, result_o=0x00000002_0000000E; stallreq_o high for 33 cycles total, low when ready_o rises.
- DIV −7/2 (0xFFFFFFF9, 0x2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → 0x00000000_80000000.
- DIVU 0xFFFFFFFF/1 → 0x00000000_FFFFFFFF. Then drop start_i → FREE, ready_o=0, result_o=0. Re-issue 9/3 next cycle → 0x00000000_00000003.
- DIVU 5/0 with DIV_ZERO_DETECT_EN → ready_o on cycle after BYZERO, result 0. Without the macro → after 32 cycles 0x00000005_FFFFFFFF.
- Assert annul_i at iteration 10 → next cycle FREE, stallreq_o=0, ready_o never rises. Then a start with 20/4 completes normally with quotient 5.
- Assert rst at iteration 20 → state FREE, result_o=0, ready_o=0, stallreq_o follows start_i only.
